// File: rtl/cpu_arb_pkg.sv
// cpu_arb_pkg: shared FSM states and constants for the CPU memory-port arbiter.
package cpu_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_t;
    localparam int PORT_IFETCH = 0;
    localparam int PORT_DATA   = 1;
    localparam int ARB_DW      = 16;
endpackage

// File: rtl/mux2.sv
// mux2: the existing W-bit 2:1 mux feeding the memory-port capture registers.
module mux2 #(
    parameter int W = 16
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick; the port that did not win last goes first on contention.
module rr_pick2
    import cpu_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);
    assign any    = |req;
    assign winner = (req == 2'b11) ? ~last : req[PORT_DATA];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin IDLE/BUSY/DONE sequencer sharing one memory port between ifetch and data.
// Define ARB_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT_CYCLES cycles without mem_ready.
module mem_port_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int DW = ARB_DW
`ifdef ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req,
    input  logic [DW-1:0] addr0,
    input  logic [DW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [1:0]    we,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          mem_sel,
    output logic          mem_valid,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);
    arb_state_t    state;
    logic          last, winner, any;
    logic [DW-1:0] addr_mux, wdata_mux;

    rr_pick2 u_pick (.req(req), .last(last), .winner(winner), .any(any));
    mux2 #(.W(DW)) u_addr_mux  (.sel(winner), .a(addr0),  .b(addr1),  .y(addr_mux));
    mux2 #(.W(DW)) u_wdata_mux (.sel(winner), .a(wdata0), .b(wdata1), .y(wdata_mux));

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            last      <= 1'b1;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            mem_sel   <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err       <= 1'b0;
            tcnt      <= '0;
`endif
        end else begin
            case (state)
                ARB_IDLE: if (any) begin
                    state     <= ARB_BUSY;
                    mem_addr  <= addr_mux;
                    mem_wdata <= wdata_mux;
                    mem_we    <= we[winner];
                    mem_sel   <= winner;
                    gnt       <= winner ? 2'b10 : 2'b01;
                    mem_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                    tcnt      <= '0;
`endif
                end
                ARB_BUSY: if (mem_ready) begin
                    state     <= ARB_DONE;
                    rdata     <= mem_rdata;
                    done      <= gnt;
                    mem_valid <= 1'b0;
                    last      <= mem_sel;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tcnt == TLAST) begin
                    // Abort: complete toward the requester with err and zero data.
                    state     <= ARB_DONE;
                    rdata     <= '0;
                    done      <= gnt;
                    err       <= 1'b1;
                    mem_valid <= 1'b0;
                    last      <= mem_sel;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
`endif
                ARB_DONE: begin
                    state <= ARB_IDLE;
                    done  <= '0;
                    gnt   <= '0;
`ifdef ARB_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed-vector bench for mem_port_arbiter (also covers ARB_TIMEOUT_EN when defined).
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we, gnt, done;
    logic [15:0] addr0, addr1, wdata0, wdata1, rdata, mem_addr, mem_wdata, mem_rdata;
    logic        err, mem_sel, mem_valid, mem_we, mem_ready;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
`else
    mem_port_arbiter dut (
`endif
        .clk(clk), .rst_n(rst_n), .req(req), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .we(we), .gnt(gnt), .done(done),
        .rdata(rdata), .err(err), .mem_sel(mem_sel), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; we = '0; mem_ready = 1'b0; mem_rdata = '0;
        addr0 = 16'h0040; addr1 = 16'h0180; wdata0 = 16'h0000; wdata1 = 16'h0000;
        #1;
        chk("rst_gnt", {14'd0, gnt}, 16'd0);
        chk("rst_valid", {15'd0, mem_valid}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        tick(); rst_n = 1'b1; tick();

        // reset mid-BUSY
        req = 2'b01; tick();
        chk("t1_valid", {15'd0, mem_valid}, 16'd1);
        chk("t1_addr", mem_addr, 16'h0040);
        #2 rst_n = 1'b0; #1;
        chk("t1_async_valid", {15'd0, mem_valid}, 16'd0);
        chk("t1_async_gnt", {14'd0, gnt}, 16'd0);
        chk("t1_async_addr", mem_addr, 16'h0000);
        req = 2'b00; tick(); rst_n = 1'b1; tick();
        chk("t1_post_done", {14'd0, done}, 16'd0);
        chk("t1_post_valid", {15'd0, mem_valid}, 16'd0);

        // contention after reset: port0 first, then alternate
        req = 2'b11; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 16'hA000 + 16'(i);
            tick();
            chk("t3_gnt", {14'd0, gnt}, (i % 2) ? 16'd2 : 16'd1);
            chk("t3_sel", {15'd0, mem_sel}, 16'(i % 2));
            chk("t3_addr", mem_addr, (i % 2) ? 16'h0180 : 16'h0040);
            tick();
            chk("t3_done", {14'd0, done}, (i % 2) ? 16'd2 : 16'd1);
            chk("t3_rdata", rdata, 16'hA000 + 16'(i));
            tick();
            chk("t3_done_clr", {14'd0, done}, 16'd0);
        end
        req = 2'b00; mem_ready = 1'b0; tick();

        // single read on port0
        req = 2'b01; addr0 = 16'h0040; tick();
        chk("t2_sel", {15'd0, mem_sel}, 16'd0);
        chk("t2_addr", mem_addr, 16'h0040);
        chk("t2_we", {15'd0, mem_we}, 16'd0);
        mem_ready = 1'b1; mem_rdata = 16'hBEEF; tick();
        chk("t2_done", {14'd0, done}, 16'd1);
        chk("t2_rdata", rdata, 16'hBEEF);
        chk("t2_valid_off", {15'd0, mem_valid}, 16'd0);
        mem_ready = 1'b0; mem_rdata = 16'h1111; req = 2'b00; tick();
        chk("t2_done_clr", {14'd0, done}, 16'd0);
        chk("t2_rdata_hold", rdata, 16'hBEEF);

        // store on port1, mem_ready on the 4th BUSY cycle
        req = 2'b10; we = 2'b10; addr1 = 16'h0100; wdata1 = 16'h1234; tick();
        req = 2'b00; we = 2'b00; wdata1 = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            chk("t4_we", {15'd0, mem_we}, 16'd1);
            chk("t4_wdata", mem_wdata, 16'h1234);
            chk("t4_addr", mem_addr, 16'h0100);
            chk("t4_done_wait", {14'd0, done}, 16'd0);
            if (k == 3) mem_ready = 1'b1;
            tick();
        end
        chk("t4_done", {14'd0, done}, 16'd2);
        chk("t4_err", {15'd0, err}, 16'd0);
        mem_ready = 1'b0; tick();

        // port0 drops req during BUSY, transaction still completes
        req = 2'b01; addr0 = 16'h0222; tick();
        req = 2'b00; tick();
        chk("t5_valid", {15'd0, mem_valid}, 16'd1);
        chk("t5_addr", mem_addr, 16'h0222);
        mem_ready = 1'b1; mem_rdata = 16'h5A5A; tick();
        chk("t5_done", {14'd0, done}, 16'd1);
        chk("t5_rdata", rdata, 16'h5A5A);
        mem_ready = 1'b0; tick();

`ifdef ARB_TIMEOUT_EN
        // timeout after 4 BUSY cycles
        req = 2'b01; tick(); req = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_wait", {14'd0, done}, 16'd0);
        end
        tick();
        chk("t6_done", {14'd0, done}, 16'd1);
        chk("t6_err", {15'd0, err}, 16'd1);
        chk("t6_rdata", rdata, 16'h0000);
        tick();
        chk("t6_err_clr", {15'd0, err}, 16'd0);
        // mem_ready on the 4th BUSY cycle wins over timeout
        req = 2'b01; tick(); req = 2'b00;
        tick(); tick(); tick();
        mem_ready = 1'b1; mem_rdata = 16'h7777; tick();
        chk("t6b_done", {14'd0, done}, 16'd1);
        chk("t6b_err", {15'd0, err}, 16'd0);
        chk("t6b_rdata", rdata, 16'h7777);
        mem_ready = 1'b0; tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
